lif_output_layer: RTL and testbench

- Output-neuron stage of the SNN core, directly upstream of the post-core spike counter/decider.
- Takes per-time-unit synaptic current totals for N output neurons and runs a leaky integrate-and-fire update with refractory period for each neuron.
- Emits the spike vector `ops` together with the `coring`, `TU_incre` and `done_core_img` strobes that the decider consumes.
- Sequences a fixed number of time units per image.

---
 rtl/lif_output_layer.sv | 167 ++++++++++++++++
 tb/tb_lif_output_layer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_output_layer.sv
// lif_output_layer: leaky integrate-and-fire stage for the SNN output neurons.
// Collects per-time-unit synaptic current words and updates one neuron per cycle.
// After the update it emits a spike vector with a time-unit strobe, and it
// sequences T_STEPS time units per image.
module lif_output_layer #(
  parameter int N       = 8,
  parameter int IW      = 3,
  parameter int W       = 24,
  parameter int TH      = 15018,
  parameter int D       = 614,
  parameter int PRES    = 0,
  parameter int PMIN    = -2048000,
  parameter int REF     = 30,
  parameter int T_STEPS = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_img,
  input  logic                cur_valid,
  output logic                cur_ready,
  input  logic [IW-1:0]       cur_idx,
  input  logic signed [W-1:0] cur_in,
  input  logic                cur_last,
  output logic                coring,
  output logic [N-1:0]        ops,
  output logic                TU_incre,
  output logic                done_core_img
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(REF + 1);
  localparam int TW = $clog2(T_STEPS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_EMIT   = 2'd3;

  localparam logic signed [W-1:0]   PRES_W   = W'(PRES);
  localparam logic signed [W+1:0]   PMIN_X   = (W+2)'(PMIN);
  localparam logic signed [W+1:0]   TH_X     = (W+2)'(TH);
  localparam logic signed [W+1:0]   D_X      = (W+2)'(D);
  localparam logic [IW:0]           N_L      = (IW+1)'(N);
  localparam logic [AW-1:0]         LAST_IDX = AW'(N - 1);
  localparam logic [TW-1:0]         LAST_TU  = TW'(T_STEPS - 1);
  localparam logic [RW-1:0]         REF_R    = RW'(REF);

  // Saturating signed add, clamps to the W-bit two's complement range.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] sum;
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1])
      return sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return sum[W-1:0];
  endfunction

  // Potential floor; the wide value is kept so threshold compares see any headroom.
  function automatic logic signed [W+1:0] floor_clamp(input logic signed [W+1:0] x);
    return (x < PMIN_X) ? PMIN_X : x;
  endfunction

  logic [1:0]          state;
  logic [TW-1:0]       tu_cnt;
  logic [AW-1:0]       upd_idx;
  logic [N-1:0]        s_r;
  logic signed [W-1:0] pot  [N];
  logic signed [W-1:0] acc  [N];
  logic [RW-1:0]       refr [N];

  logic signed [W-1:0] p_cur;
  logic signed [W-1:0] a_cur;
  logic [RW-1:0]       r_cur;
  logic signed [W+1:0] leak_x;
  logic signed [W+1:0] pn_x;
  logic                fire;
  logic [N-1:0]        s_nxt;

  assign cur_ready     = (state == S_ACCUM);
  assign coring        = (state != S_IDLE);
  assign TU_incre      = (state == S_EMIT);
  assign done_core_img = (state == S_EMIT) && (tu_cnt == LAST_TU);

  // Candidate potential and spike decision for the neuron currently being updated.
  always_comb begin
    p_cur  = pot[upd_idx];
    a_cur  = acc[upd_idx];
    r_cur  = refr[upd_idx];
    leak_x = (p_cur > PRES_W) ? D_X : '0;
    pn_x   = floor_clamp({{2{p_cur[W-1]}}, p_cur} + {{2{a_cur[W-1]}}, a_cur} - leak_x);
    fire   = (r_cur == '0) && (pn_x >= TH_X);
    s_nxt  = s_r;
    s_nxt[upd_idx] = fire;
  end

  // Sequencer plus neuron state: accumulate, update one neuron per cycle, emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tu_cnt  <= '0;
      upd_idx <= '0;
      s_r     <= '0;
      ops     <= '0;
      for (int i = 0; i < N; i++) begin
        pot[i]  <= PRES_W;
        acc[i]  <= '0;
        refr[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_img) begin
            state   <= S_ACCUM;
            upd_idx <= '0;
          end
        end
        S_ACCUM: begin
          if (cur_valid) begin
            // Out-of-range indices complete the handshake but contribute nothing.
            if ({1'b0, cur_idx} < N_L)
              acc[cur_idx[AW-1:0]] <= sat_add(acc[cur_idx[AW-1:0]], cur_in);
            if (cur_last) begin
              state   <= S_UPDATE;
              upd_idx <= '0;
            end
          end
        end
        S_UPDATE: begin
          acc[upd_idx] <= '0;
          s_r          <= s_nxt;
          if (r_cur != '0) begin
            refr[upd_idx] <= r_cur - RW'(1);
            pot[upd_idx]  <= PRES_W;
          end else if (fire) begin
            refr[upd_idx] <= REF_R;
            pot[upd_idx]  <= PRES_W;
          end else begin
            pot[upd_idx]  <= pn_x[W-1:0];
          end
          if (upd_idx == LAST_IDX) begin
            ops     <= s_nxt;
            upd_idx <= '0;
            state   <= S_EMIT;
          end else begin
            upd_idx <= upd_idx + AW'(1);
          end
        end
        S_EMIT: begin
          if (tu_cnt == LAST_TU) begin
            // Image finished: leave no neuron history behind for the next one.
            tu_cnt <= '0;
            for (int i = 0; i < N; i++) begin
              pot[i]  <= PRES_W;
              refr[i] <= '0;
            end
            state <= S_IDLE;
          end else begin
            tu_cnt <= tu_cnt + TW'(1);
            state  <= S_ACCUM;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_output_layer.sv
// Bench for lif_output_layer: two instances (long image with a 4-bit index
// bus, short 4-step image) against an integer reference model of the neurons.
`timescale 1ns/1ps
module tb_lif_output_layer;
  localparam int N    = 8;
  localparam int W    = 24;
  localparam int TS_A = 50;
  localparam int TS_B = 4;
  localparam int TH   = 15018;
  localparam int D    = 614;
  localparam int PMIN = -2048000;
  localparam int REFR = 30;
  localparam longint AMAX = 64'sd8388607;
  localparam longint AMIN = -64'sd8388608;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, vld_a, last_a, rdy_a, coring_a, tu_a, done_a;
  logic [3:0] idx_a;
  logic signed [W-1:0] in_a;
  logic [N-1:0] ops_a;
  logic rst_b, start_b, vld_b, last_b, rdy_b, coring_b, tu_b, done_b;
  logic [2:0] idx_b;
  logic signed [W-1:0] in_b;
  logic [N-1:0] ops_b;

  lif_output_layer #(.N(N), .IW(4), .W(W), .T_STEPS(TS_A)) dut_a (
    .clk(clk), .rst(rst_a), .start_img(start_a), .cur_valid(vld_a), .cur_ready(rdy_a),
    .cur_idx(idx_a), .cur_in(in_a), .cur_last(last_a), .coring(coring_a), .ops(ops_a),
    .TU_incre(tu_a), .done_core_img(done_a));

  lif_output_layer #(.N(N), .IW(3), .W(W), .T_STEPS(TS_B)) dut_b (
    .clk(clk), .rst(rst_b), .start_img(start_b), .cur_valid(vld_b), .cur_ready(rdy_b),
    .cur_idx(idx_b), .cur_in(in_b), .cur_last(last_b), .coring(coring_b), .ops(ops_b),
    .TU_incre(tu_b), .done_core_img(done_b));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_a = 0;
  int issued_a = 0;
  int tu_seen_b = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vld_a && rdy_a) hs_a <= hs_a + 1;
    if (tu_b) tu_seen_b <= tu_seen_b + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer potentials, refractory counts and per-TU sums.
  int mP [N];
  int mR [N];
  longint macc [N];
  bit [N-1:0] mS;
  typedef struct { int idx; int val; } word_t;
  word_t wq[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mP[i] = 0; mR[i] = 0; macc[i] = 0;
    end
    mS = '0;
  endfunction

  function automatic void model_word(input int idx, input int val);
    longint t;
    if (idx < N) begin
      t = macc[idx] + longint'(val);
      if (t > AMAX) t = AMAX;
      if (t < AMIN) t = AMIN;
      macc[idx] = t;
    end
  endfunction

  function automatic void model_step();
    int pn;
    for (int i = 0; i < N; i++) begin
      if (mR[i] > 0) begin
        mR[i] = mR[i] - 1; mP[i] = 0; mS[i] = 1'b0;
      end else begin
        pn = mP[i] + int'(macc[i]) - ((mP[i] > 0) ? D : 0);
        if (pn < PMIN) pn = PMIN;
        if (pn >= TH) begin
          mS[i] = 1'b1; mP[i] = 0; mR[i] = REFR;
        end else begin
          mS[i] = 1'b0; mP[i] = pn;
        end
      end
      macc[i] = 0;
    end
  endfunction

  // Offer one word to instance A with a random idle gap; returns the cycle stamp after acceptance.
  task automatic send_a(input int idx, input int val, input bit last, output int acc_cyc);
    int budget;
    int gap;
    gap = int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) begin
      vld_a = 1'b0;
      @(negedge clk);
    end
    vld_a = 1'b1; idx_a = 4'(idx); in_a = W'(val); last_a = last;
    budget = 100;
    while (!rdy_a && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("ready_wait_a", 64'(budget > 0), 64'd1);
    @(posedge clk);
    issued_a++;
    model_word(idx, val);
    @(negedge clk);
    vld_a = 1'b0; last_a = 1'b0;
    acc_cyc = cyc;
  endtask

  // Send the queued words of one time unit, then check the emitted spike vector.
  task automatic run_tu_a(input int tu, output bit [N-1:0] got);
    int c_acc;
    int k;
    int n;
    c_acc = 0;
    n = wq.size();
    for (int j = 0; j < n; j++) send_a(wq[j].idx, wq[j].val, (j == n - 1), c_acc);
    wq.delete();
    model_step();
    k = 0;
    while (!tu_a && k < 3 * N) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("tu_pulse_a_tu%0d", tu), 64'(tu_a), 64'd1);
    chk($sformatf("latency_a_tu%0d", tu), 64'(cyc - c_acc + 1), 64'(N + 1));
    chk($sformatf("ops_a_tu%0d", tu), 64'(ops_a), 64'(mS));
    chk($sformatf("done_a_tu%0d", tu), 64'(done_a), 64'(tu == TS_A));
    chk($sformatf("coring_emit_a_tu%0d", tu), 64'(coring_a), 64'd1);
    got = ops_a;
    @(negedge clk);
  endtask

  initial begin
    bit [N-1:0] got;
    int c;
    int k;
    int hs0;
    int iss0;
    rst_a = 1'b1; start_a = 1'b0; vld_a = 1'b0; last_a = 1'b0; idx_a = '0; in_a = '0;
    rst_b = 1'b1; start_b = 1'b0; vld_b = 1'b0; last_b = 1'b0; idx_b = '0; in_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready_a", 64'(rdy_a), 64'd0);
    chk("rst_coring_a", 64'(coring_a), 64'd0);
    chk("rst_tu_a", 64'(tu_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_ops_a", 64'(ops_a), 64'd0);
    chk("rst_coring_b", 64'(coring_b), 64'd0);
    chk("rst_ready_b", 64'(rdy_b), 64'd0);
    chk("rst_ops_b", 64'(ops_b), 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Short image on instance B: four cur_last-only time units.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("start_coring_b", 64'(coring_b), 64'd1);
    chk("start_ready_b", 64'(rdy_b), 64'd1);
    for (int t = 1; t <= TS_B; t++) begin
      vld_b = 1'b1; idx_b = 3'd0; in_b = '0; last_b = 1'b1;
      k = 0;
      while (!rdy_b && k < 50) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
      vld_b = 1'b0; last_b = 1'b0;
      if (t == 2) begin
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
      end
      k = 0;
      while (!tu_b && k < 3 * N) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("tu_pulse_b%0d", t), 64'(tu_b), 64'd1);
      chk($sformatf("done_b%0d", t), 64'(done_b), 64'(t == TS_B));
      chk($sformatf("coring_b%0d", t), 64'(coring_b), 64'd1);
      chk($sformatf("ops_b%0d", t), 64'(ops_b), 64'd0);
      @(negedge clk);
    end
    chk("end_coring_b", 64'(coring_b), 64'd0);
    chk("end_tu_b", 64'(tu_b), 64'd0);
    repeat (20) @(negedge clk);
    chk("tu_count_b", 64'(tu_seen_b), 64'(TS_B));
    chk("idle_coring_b", 64'(coring_b), 64'd0);

    // Reset while accumulating with a pending current on neuron 0.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_coring_a", 64'(coring_a), 64'd1);
    send_a(0, 100000, 1'b0, c);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_coring_a", 64'(coring_a), 64'd0);
    chk("midrst_ready_a", 64'(rdy_a), 64'd0);
    chk("midrst_tu_a", 64'(tu_a), 64'd0);
    chk("midrst_done_a", 64'(done_a), 64'd0);
    chk("midrst_ops_a", 64'(ops_a), 64'd0);
    rst_a = 1'b0;
    model_reset();
    @(negedge clk);

    // All-zero currents for a few time units, then abort.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      wq.push_back('{0, 0});
      run_tu_a(t, got);
      chk($sformatf("zero_ops_tu%0d", t), 64'(got), 64'd0);
    end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    model_reset();
    @(negedge clk);

    // Full image with directed neurons 0..4 and random neurons 5..7.
    hs0 = hs_a; iss0 = issued_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int t = 1; t <= TS_A; t++) begin
      wq.push_back('{0, 4096});
      if (t == 2)  wq.push_back('{3, -3000000});
      if (t == 20) wq.push_back('{3, 2063018});
      if (t == 30) begin
        wq.push_back('{4, 8388607});
        wq.push_back('{4, 8388607});
      end
      if (t == TS_A) wq.push_back('{1, 10000});
      for (int n = 5; n < N; n++)
        if ($urandom_range(0, 1) == 1)
          wq.push_back('{n, int'($urandom_range(0, 12000)) - 4000});
      if (t == 10) begin
        wq.push_back('{2, 8000});
        wq.push_back('{2, 8000});
        wq.push_back('{9, 12345});
      end
      run_tu_a(t, got);
      chk($sformatf("n0_spike_tu%0d", t), 64'(got[0]), 64'(t == 5 || t == 40));
      if (t == 10) chk("split_n2_spike", 64'(got[2]), 64'd1);
      if (t == 20) chk("floor_n3_spike", 64'(got[3]), 64'd1);
      if (t == 30) chk("sat_n4_spike", 64'(got[4]), 64'd1);
    end
    chk("img_end_coring_a", 64'(coring_a), 64'd0);
    chk("img_end_tu_a", 64'(tu_a), 64'd0);
    chk("handshakes_a", 64'(hs_a - hs0), 64'(issued_a - iss0));

    // Back-to-back second image must start from clean neuron state.
    model_reset();
    hs0 = hs_a; iss0 = issued_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      wq.push_back('{0, 4096});
      if (t == 1) begin
        wq.push_back('{1, 6000});
        wq.push_back('{4, 15018});
      end
      run_tu_a(t, got);
      chk($sformatf("img2_n0_tu%0d", t), 64'(got[0]), 64'(t == 5));
      if (t == 1) begin
        chk("img2_n4_thresh", 64'(got[4]), 64'd1);
        chk("img2_n1_clean", 64'(got[1]), 64'd0);
      end
    end
    chk("handshakes2_a", 64'(hs_a - hs0), 64'(issued_a - iss0));
    rst_a = 1'b1;
    @(negedge clk);
    chk("abort_tu_a", 64'(tu_a), 64'd0);
    chk("abort_done_a", 64'(done_a), 64'd0);
    chk("abort_coring_a", 64'(coring_a), 64'd0);
    rst_a = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
